// File: rtl/axis_i2c_rx_packer.sv
// Packs I2C read bytes into AXI4-Stream words and buffers them in a word FIFO; overflow is sticky.
// Optional AXIS_I2C_RX_PKT_LEN_EN: automatic tlast every PKT_WORDS pushed words.
module axis_i2c_rx_packer #(
    parameter int DATA_W     = 8,
    parameter int BYTES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int PKT_WORDS  = 16
) (
    input  logic                             clk_i,
    input  logic                             arstn_i,
    input  logic [DATA_W-1:0]                i2c_rdata_i,
    input  logic                             rvalid_i,
    input  logic                             flush_i,
    output logic [DATA_W*BYTES-1:0]          m_axis_tdata,
    output logic [BYTES-1:0]                 m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             overflow_o,
    input  logic                             ovf_clr_i,
    output logic [$clog2(FIFO_DEPTH):0]      level_o
);

    localparam int WORD_W  = DATA_W * BYTES;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int CW      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int ENTRY_W = WORD_W + BYTES + 1;

    logic [BYTES-1:0][DATA_W-1:0] acc;
    logic [BYTES-1:0][DATA_W-1:0] word_data;
    logic [CW-1:0]                byte_cnt;
    logic [CW:0]                  fill_cnt;
    logic [BYTES-1:0]             word_keep;
    logic                         word_last;
    logic                         fill;
    logic                         do_flush;
    logic                         push;

    logic [ENTRY_W-1:0]           mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]           rd_entry;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [LW-1:0]                level;
    logic                         full;
    logic                         pop;
    logic                         wr_en;
    logic                         drop;

    // The incoming byte is merged before the flush decision, so a same-cycle byte+flush closes one word.
    always_comb begin
        word_data = acc;
        if (rvalid_i) begin
            word_data[byte_cnt] = i2c_rdata_i;
        end
        fill_cnt = {1'b0, byte_cnt} + {{CW{1'b0}}, rvalid_i};
        fill     = rvalid_i && (byte_cnt == CW'(BYTES - 1));
        do_flush = flush_i && (fill_cnt != '0);
        push     = fill || do_flush;
        for (int i = 0; i < BYTES; i++) begin
            word_keep[i] = (i < int'(fill_cnt));
        end
    end

`ifdef AXIS_I2C_RX_PKT_LEN_EN
    localparam int PCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    logic [PCW-1:0] pkt_cnt;
    logic           pkt_last;

    assign pkt_last  = (pkt_cnt == PCW'(PKT_WORDS - 1));
    assign word_last = do_flush || pkt_last;

    // Only words that actually enter the FIFO advance the packet count.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pkt_cnt <= '0;
        end else if (do_flush) begin
            pkt_cnt <= '0;
        end else if (wr_en) begin
            pkt_cnt <= pkt_last ? '0 : pkt_cnt + 1'b1;
        end
    end
`else
    assign word_last = do_flush;
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            acc      <= '0;
            byte_cnt <= '0;
        end else if (push) begin
            acc      <= '0;
            byte_cnt <= '0;
        end else if (rvalid_i) begin
            acc[byte_cnt] <= i2c_rdata_i;
            byte_cnt      <= byte_cnt + 1'b1;
        end
    end

    assign full  = (level == LW'(FIFO_DEPTH));
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= {word_last, word_keep, word_data};
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(wr_en) - LW'(pop);
            if (drop) begin
                overflow_o <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    // Outputs are forced to zero while empty so stale memory never leaks after reset.
    assign rd_entry      = mem[rd_ptr];
    assign m_axis_tvalid = (level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? rd_entry[WORD_W-1:0] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? rd_entry[WORD_W +: BYTES] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? rd_entry[ENTRY_W-1] : 1'b0;
    assign level_o       = level;

endmodule

// File: tb/tb_axis_i2c_rx_packer.sv
// Directed self-checking bench for axis_i2c_rx_packer (default parameters, PKT_WORDS=2 for the optional feature).
module tb_axis_i2c_rx_packer;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [7:0]  i2c_rdata_i;
    logic        rvalid_i;
    logic        flush_i;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overflow_o;
    logic        ovf_clr_i;
    logic [3:0]  level_o;

    int checks   = 0;
    int failures = 0;

    axis_i2c_rx_packer #(
        .DATA_W(8), .BYTES(4), .FIFO_DEPTH(8), .PKT_WORDS(2)
    ) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .i2c_rdata_i(i2c_rdata_i),
        .rvalid_i(rvalid_i), .flush_i(flush_i), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fl);
        i2c_rdata_i = b;
        rvalid_i    = 1'b1;
        flush_i     = fl;
        tick();
        rvalid_i    = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic send_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input int w, input int lane);
        return 8'(w * 16 + lane);
    endfunction

    function automatic logic [31:0] word_of(input int w);
        return {byte_of(w, 3), byte_of(w, 2), byte_of(w, 1), byte_of(w, 0)};
    endfunction

    task automatic send_word(input int w);
        for (int l = 0; l < 4; l++) begin
            send_byte(byte_of(w, l), 1'b0);
        end
    endtask

    initial begin
        arstn_i       = 1'b0;
        i2c_rdata_i   = '0;
        rvalid_i      = 1'b0;
        flush_i       = 1'b0;
        m_axis_tready = 1'b0;
        ovf_clr_i     = 1'b0;
        tick();
        tick();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_level", 64'(level_o), 64'd0);
        arstn_i = 1'b1;
        tick();

        // Two full words streamed with tready high
        m_axis_tready = 1'b1;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        check("w1_not_yet", 64'(m_axis_tvalid), 64'd0);
        send_byte(8'h04, 1'b0);
        check("w1_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("w1_tdata", 64'(m_axis_tdata), 64'h04030201);
        check("w1_tkeep", 64'(m_axis_tkeep), 64'hF);
        check("w1_tlast", 64'(m_axis_tlast), 64'd0);
        check("w1_level", 64'(level_o), 64'd1);
        send_byte(8'h05, 1'b0);
        check("w1_popped", 64'(m_axis_tvalid), 64'd0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b0);
        check("w2_tdata", 64'(m_axis_tdata), 64'h08070605);
        check("w2_tkeep", 64'(m_axis_tkeep), 64'hF);
        check("w2_tlast", 64'(m_axis_tlast), 64'd0);
        tick();
        check("w2_popped", 64'(m_axis_tvalid), 64'd0);

        // Partial flush, then a flush with an empty accumulator
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_flush();
        check("fl_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("fl_tdata", 64'(m_axis_tdata), 64'h0000BBAA);
        check("fl_tkeep", 64'(m_axis_tkeep), 64'h3);
        check("fl_tlast", 64'(m_axis_tlast), 64'd1);
        send_flush();
        check("fl_empty_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("fl_empty_level", 64'(level_o), 64'd0);

        // Fourth byte coinciding with flush
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        check("bf_tdata", 64'(m_axis_tdata), 64'h44332211);
        check("bf_tkeep", 64'(m_axis_tkeep), 64'hF);
        check("bf_tlast", 64'(m_axis_tlast), 64'd1);
        tick();
        check("bf_single", 64'(m_axis_tvalid), 64'd0);

        // Fill the FIFO with tready low; the 9th word overflows
        m_axis_tready = 1'b0;
        for (int w = 0; w < 8; w++) begin
            send_word(w);
        end
        check("full_level", 64'(level_o), 64'd8);
        check("full_no_ovf", 64'(overflow_o), 64'd0);
        send_word(8);
        check("ovf_level", 64'(level_o), 64'd8);
        check("ovf_set", 64'(overflow_o), 64'd1);
        tick();
        tick();
        check("hold_tdata", 64'(m_axis_tdata), 64'(word_of(0)));
        check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("ovf_clr", 64'(overflow_o), 64'd0);

        // Push and pop in the same cycle while full
        send_byte(byte_of(9, 0), 1'b0);
        send_byte(byte_of(9, 1), 1'b0);
        send_byte(byte_of(9, 2), 1'b0);
        m_axis_tready = 1'b1;
        send_byte(byte_of(9, 3), 1'b0);
        m_axis_tready = 1'b0;
        check("pp_level", 64'(level_o), 64'd8);
        check("pp_no_ovf", 64'(overflow_o), 64'd0);
        check("pp_head", 64'(m_axis_tdata), 64'(word_of(1)));

        // Drain: words 1..7, then word 9; the dropped word 8 never shows up
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_tvalid", i), 64'(m_axis_tvalid), 64'd1);
            check($sformatf("drain%0d_tdata", i), 64'(m_axis_tdata),
                  64'(word_of((i < 7) ? i + 1 : 9)));
            tick();
        end
        check("drain_empty", 64'(m_axis_tvalid), 64'd0);
        check("drain_level", 64'(level_o), 64'd0);

        // Reset mid-transfer discards buffered words and the partial word
        m_axis_tready = 1'b0;
        send_word(1);
        send_word(2);
        send_word(3);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        check("pre_rst_level", 64'(level_o), 64'd3);
        arstn_i = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_level", 64'(level_o), 64'd0);
        tick();
        arstn_i = 1'b1;
        tick();
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b0);
        check("post_rst_tdata", 64'(m_axis_tdata), 64'hC4C3C2C1);
        check("post_rst_tkeep", 64'(m_axis_tkeep), 64'hF);
        check("post_rst_level", 64'(level_o), 64'd1);
        m_axis_tready = 1'b1;
        tick();
        check("post_rst_drained", 64'(m_axis_tvalid), 64'd0);

`ifdef AXIS_I2C_RX_PKT_LEN_EN
        // Packet length of 2: tlast on every second word
        arstn_i = 1'b0;
        tick();
        arstn_i = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) begin
            send_word(w);
            check($sformatf("pkt%0d_tdata", w), 64'(m_axis_tdata), 64'(word_of(w)));
            check($sformatf("pkt%0d_tlast", w), 64'(m_axis_tlast), 64'(w % 2 == 1));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
